// File: rtl/data_sram_resp.sv
// data_sram_resp: SRAM-like data memory slave with fixed-latency in-order responses
module data_sram_resp #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   input  logic [1:0]  data_sram_size,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
   logic              r_wr  [DEPTH];
   logic [31:0]       r_rd  [DEPTH];
   logic [2:0]        r_tmr [DEPTH];
   logic [PW-1:0]     r_head, r_tail;
   logic [CW-1:0]     r_count;
   logic              w_acc, w_pop, w_wr, w_unused;
   logic [ADDR_W-1:0] w_idx;
   logic [3:0]        w_mask, w_be;
   logic [31:0]       w_rword;
   logic [PW-1:0]     w_head_nxt, w_tail_nxt;
   assign w_idx      = data_sram_addr[ADDR_W+1:2];
   assign w_unused   = &{1'b0, data_sram_addr[31:ADDR_W+2]};
   assign w_mask     = data_sram_size == 2'd0 ? 4'b0001 << data_sram_addr[1:0] :
                       data_sram_size == 2'd1 ? (data_sram_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign w_be       = data_sram_we & w_mask;
   assign w_wr       = |data_sram_we;
   assign w_rword    = r_mem[w_idx];
   assign w_pop      = r_count != '0 && r_tmr[r_head] == 3'd0;
   assign w_acc      = data_sram_en && data_sram_addr_ok;
   assign w_head_nxt = r_head == PW'(DEPTH-1) ? '0 : r_head + 1'b1;
   assign w_tail_nxt = r_tail == PW'(DEPTH-1) ? '0 : r_tail + 1'b1;
   assign data_sram_addr_ok = r_count < CW'(DEPTH) || w_pop;
   assign data_sram_data_ok = w_pop;
   assign data_sram_rdata   = w_pop && !r_wr[r_head] ? r_rd[r_head] : 32'h0;
   // byte-masked store at the accepting edge; memory contents survive reset
   always_ff @(posedge clk) begin
      if (w_acc && w_wr)
         for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
   end
   // queue payload: write flag and the word read in the accept cycle
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_wr[r_tail] <= w_wr;
         r_rd[r_tail] <= w_wr ? 32'h0 : w_rword;
      end
   end
   // queue control: timers count down, head pops when its timer hits zero
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_tmr[i] <= 3'd0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (r_tmr[i] != 3'd0) r_tmr[i] <= r_tmr[i] - 3'd1;
         if (w_acc) begin
            r_tmr[r_tail] <= 3'(LATENCY-1);
            r_tail        <= w_tail_nxt;
         end
         if (w_pop) r_head <= w_head_nxt;
         r_count <= r_count + CW'(w_acc) - CW'(w_pop);
      end
   end
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: scoreboard bench over three latency/depth configurations
module tb_data_sram_resp;
   logic              clk = 1'b0, resetn = 1'b0, en = 1'b0;
   logic [3:0]        we = '0;
   logic [31:0]       addr = '0, wd = '0;
   logic [1:0]        size = '0;
   logic [2:0]        aok, dok;
   logic [2:0][31:0]  rdv;
   int                cyc = 0, n_chk = 0, n_pass = 0;
   int                a0, a1, a2;
   logic [5:0]        p1 = 6'b011011;
   logic [31:0]       ta [6] = '{32'h10, 32'h14, 32'h0, 32'h10, 32'h14, 32'h0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [3:0] bmask(input logic [1:0] s, input logic [1:0] a);
      case (s)
         2'd0:    return 4'b0001 << a;
         2'd1:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   data_sram_resp #(.ADDR_W(10), .LATENCY(2), .DEPTH(2)) u0 (
      .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr),
      .data_sram_wdata(wd), .data_sram_size(size), .data_sram_addr_ok(aok[0]),
      .data_sram_data_ok(dok[0]), .data_sram_rdata(rdv[0]));
   data_sram_resp #(.ADDR_W(10), .LATENCY(3), .DEPTH(2)) u1 (
      .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr),
      .data_sram_wdata(wd), .data_sram_size(size), .data_sram_addr_ok(aok[1]),
      .data_sram_data_ok(dok[1]), .data_sram_rdata(rdv[1]));
   data_sram_resp #(.ADDR_W(10), .LATENCY(3), .DEPTH(3)) u2 (
      .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr),
      .data_sram_wdata(wd), .data_sram_size(size), .data_sram_addr_ok(aok[2]),
      .data_sram_data_ok(dok[2]), .data_sram_rdata(rdv[2]));

   for (genvar g = 0; g < 3; g++) begin : mon
      localparam int L = (g == 0) ? 2 : 3;
      logic [63:0] q [$];
      logic [63:0] e;
      logic [31:0] m [0:1023];
      logic [3:0]  be;
      logic [9:0]  ix;
      int          nacc = 0;
      always @(negedge clk) begin
         if (!resetn) q.delete();
         else begin
            if (dok[g]) begin
               if (q.size() == 0) chk($sformatf("spurious%0d", g), 32'd1, 32'd0);
               else begin
                  e = q.pop_front();
                  chk($sformatf("rdata%0d", g), rdv[g], e[31:0]);
                  chk($sformatf("lat%0d", g), 32'(cyc), e[63:32]);
               end
            end
            if (en && aok[g]) begin
               nacc++;
               ix = addr[11:2];
               if (we != 4'h0) begin
                  be = we & bmask(size, addr[1:0]);
                  for (int i = 0; i < 4; i++)
                     if (be[i]) m[ix][8*i +: 8] = wd[8*i +: 8];
                  q.push_back({32'(cyc + L), 32'h0});
               end else q.push_back({32'(cyc + L), m[ix]});
            end
         end
      end
   end

   task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      @(posedge clk); #1;
      en = 1'b1; we = w; addr = a; wd = d; size = s;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         en = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_aok%0d", k), 32'(aok[k]), 32'd1);
         chk($sformatf("rst_dok%0d", k), 32'(dok[k]), 32'd0);
         chk($sformatf("rst_rdata%0d", k), rdv[k], 32'h0);
      end
      @(posedge clk); #1 resetn = 1'b1;
      req(4'hf, 32'h10, 32'h11223344, 2'd2);
      req(4'h0, 32'h10, 32'h0, 2'd2);
      idle(6);
      req(4'hf, 32'h12, 32'hAAAAAAAA, 2'd0);
      req(4'h0, 32'h10, 32'h0, 2'd2);
      idle(6);
      req(4'hf, 32'h14, 32'h55667788, 2'd2);
      req(4'hf, 32'h16, 32'hBEEFBEEF, 2'd1);
      req(4'h0, 32'h14, 32'h0, 2'd2);
      idle(6);
      req(4'h3, 32'h18, 32'hCCCCCCCC, 2'd2);
      req(4'hf, 32'h1B, 32'h5A5A5A5A, 2'd0);
      req(4'h0, 32'h18, 32'h0, 2'd2);
      idle(6);
      req(4'hf, 32'h1000, 32'h1, 2'd2);
      req(4'h0, 32'h0, 32'h0, 2'd2);
      idle(6);
      req(4'h0, 32'h10, 32'h0, 2'd2);
      req(4'h0, 32'h14, 32'h0, 2'd2);
      @(posedge clk); #1;
      en = 1'b0; resetn = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk($sformatf("midrst_dok%0d", k), 32'(dok[k]), 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rel_aok%0d", k), 32'(aok[k]), 32'd1);
         chk($sformatf("rel_dok%0d", k), 32'(dok[k]), 32'd0);
      end
      req(4'h0, 32'h10, 32'h0, 2'd2);
      idle(6);
      a0 = mon[0].nacc; a1 = mon[1].nacc; a2 = mon[2].nacc;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         en = 1'b1; we = 4'h0; addr = ta[i]; size = 2'd2;
         @(negedge clk);
         chk($sformatf("b2b_aok1_c%0d", i), 32'(aok[1]), 32'(p1[i]));
         chk($sformatf("b2b_aok2_c%0d", i), 32'(aok[2]), 32'd1);
      end
      idle(10);
      chk("b2b_acc0", 32'(mon[0].nacc - a0), 32'd6);
      chk("b2b_acc1", 32'(mon[1].nacc - a1), 32'd4);
      chk("b2b_acc2", 32'(mon[2].nacc - a2), 32'd6);
      chk("drain0", 32'(mon[0].q.size()), 32'd0);
      chk("drain1", 32'(mon[1].q.size()), 32'd0);
      chk("drain2", 32'(mon[2].q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
